// File: rtl/ntt_pkg.sv
// Shared defaults and helpers for the NTT coefficient path.
package ntt_pkg;

   localparam int unsigned NTT_W     = 32;
   localparam int unsigned NTT_N     = 8;
   localparam logic [31:0] NTT_Q     = 32'd134221489;
   localparam logic [31:0] NTT_OMEGA = 32'd0;

   typedef logic [NTT_W-1:0] coeff_t;

   // Reverse the low nbits bits of idx; bits above nbits are dropped.
   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < nbits) r = (r << 1) | ((idx >> i) & 32'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_coeff_loader_if.sv
// Coefficient input stream: one beat per accepted cycle, valid/ready handshake.
interface ntt_coeff_loader_if
   import ntt_pkg::*;
#(
   parameter int unsigned W = NTT_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_coeff;
   logic         in_last;
   logic         in_mode;

   modport master (output in_valid, in_coeff, in_last, in_mode, input in_ready);
   modport slave  (input in_valid, in_coeff, in_last, in_mode, output in_ready);
endinterface

// File: rtl/ntt_coeff_bank.sv
// One frame buffer: N coefficient words with a single write port and a
// parallel read of every word, plus the frame's NTT/iNTT mode bit.
module ntt_coeff_bank
   import ntt_pkg::*;
#(
   parameter int unsigned W = NTT_W,
   parameter int unsigned N = NTT_N
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [$clog2(N)-1:0] widx,
   input  logic [W-1:0]         wdata,
   input  logic                 mode_we,
   input  logic                 mode_in,
   output logic [W-1:0]         rd_data [0:N-1],
   output logic                 rd_mode
);

   always_ff @(posedge clk) begin
      if (we) rd_data[widx] <= wdata;
      if (mode_we) rd_mode <= mode_in;
   end

endmodule

// File: rtl/ntt_coeff_loader.sv
// Range-checks a coefficient stream, optionally bit-reverses it, double-buffers
// N-word frames and issues each one as a single-cycle parallel vector.
module ntt_coeff_loader
   import ntt_pkg::*;
#(
   parameter int unsigned  W         = NTT_W,
   parameter int unsigned  N         = NTT_N,
   parameter logic [W-1:0] Modulus_Q = W'(NTT_Q),
   parameter int unsigned  BITREV    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   ntt_coeff_loader_if.slave    src,
   input  logic                 issue_en,
   output logic [W-1:0]         Data_out [0:N-1],
   output logic                 data_valid_out,
   output logic                 iNTT_mode_out,
   output logic                 coeff_err,
   output logic                 len_err
);

   localparam int unsigned    LW       = $clog2(N);
   localparam logic [LW-1:0]  LAST_IDX = LW'(N - 1);

   // Out-of-range coefficients are replaced by zero rather than reduced.
   function automatic logic [W-1:0] range_fix(input logic [W-1:0] c);
      return (c < Modulus_Q) ? c : '0;
   endfunction

   function automatic logic out_of_range(input logic [W-1:0] c);
      return c >= Modulus_Q;
   endfunction

   logic [1:0]    full;
   logic          wr_bank;
   logic          rd_bank;
   logic [LW-1:0] cnt;

   logic          accept;
   logic          wrap;
   logic          issue;
   logic [LW-1:0] widx;
   logic [W-1:0]  wdata;

   logic [W-1:0]  bank0_data [0:N-1];
   logic [W-1:0]  bank1_data [0:N-1];
   logic          bank0_mode;
   logic          bank1_mode;

   // Ready looks only at registered state, so issue_en never reaches in_ready.
   assign src.in_ready = !reset && !full[wr_bank];
   assign accept       = src.in_valid && src.in_ready;
   assign wrap         = accept && (cnt == LAST_IDX);
   assign issue        = full[rd_bank] && issue_en;
   assign widx         = (BITREV != 0) ? LW'(bitrev(32'(cnt), LW)) : cnt;
   assign wdata        = range_fix(src.in_coeff);

   ntt_coeff_bank #(.W(W), .N(N)) u_bank0 (
      .clk     (clk),
      .we      (accept && !wr_bank),
      .widx    (widx),
      .wdata   (wdata),
      .mode_we (accept && !wr_bank && (cnt == '0)),
      .mode_in (src.in_mode),
      .rd_data (bank0_data),
      .rd_mode (bank0_mode)
   );

   ntt_coeff_bank #(.W(W), .N(N)) u_bank1 (
      .clk     (clk),
      .we      (accept && wr_bank),
      .widx    (widx),
      .wdata   (wdata),
      .mode_we (accept && wr_bank && (cnt == '0)),
      .mode_in (src.in_mode),
      .rd_data (bank1_data),
      .rd_mode (bank1_mode)
   );

   // Stage p0: frame assembly control. A completing bank is never the one
   // being issued (it cannot be full yet), so both full bits update safely.
   always_ff @(posedge clk) begin
      if (reset) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         cnt       <= '0;
         coeff_err <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= cnt + 1'b1;
            if (out_of_range(src.in_coeff)) coeff_err <= 1'b1;
            if (src.in_last != (cnt == LAST_IDX)) len_err <= 1'b1;
         end
         if (wrap) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end
         if (issue) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   // Stage p1: issued frame register; holds the last frame between issues.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_valid_out <= 1'b0;
         iNTT_mode_out  <= 1'b0;
         for (int i = 0; i < int'(N); i++) Data_out[i] <= '0;
      end else begin
         data_valid_out <= issue;
         if (issue) begin
            iNTT_mode_out <= rd_bank ? bank1_mode : bank0_mode;
            for (int i = 0; i < int'(N); i++)
               Data_out[i] <= rd_bank ? bank1_data[i] : bank0_data[i];
         end
      end
   end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Scoreboard bench: natural-order and bit-reversed loaders share one stimulus stream.
module tb_ntt_coeff_loader;
   import ntt_pkg::*;

   localparam int unsigned W    = 32;
   localparam int unsigned N    = 8;
   localparam int unsigned LOGN = 3;
   localparam logic [31:0] Q    = 32'd134221489;

   typedef struct packed {
      logic               mode;
      logic [N-1:0][W-1:0] nat;
      logic [N-1:0][W-1:0] rev;
   } frame_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         issue_en = 1'b0;
   logic         valid = 1'b0;
   logic [W-1:0] coeff = '0;
   logic         last = 1'b0;
   logic         mode = 1'b0;

   logic [W-1:0] dout0 [0:N-1];
   logic [W-1:0] dout1 [0:N-1];
   logic         dv0, dv1, m0, m1, ce0, ce1, le0, le1;

   always #5 clk = ~clk;

   ntt_coeff_loader_if #(.W(W)) if0 ();
   ntt_coeff_loader_if #(.W(W)) if1 ();

   assign if0.in_valid = valid;
   assign if0.in_coeff = coeff;
   assign if0.in_last  = last;
   assign if0.in_mode  = mode;
   assign if1.in_valid = valid;
   assign if1.in_coeff = coeff;
   assign if1.in_last  = last;
   assign if1.in_mode  = mode;

   ntt_coeff_loader #(.W(W), .N(N), .Modulus_Q(Q), .BITREV(0)) dut0 (
      .clk(clk), .reset(reset), .src(if0), .issue_en(issue_en),
      .Data_out(dout0), .data_valid_out(dv0), .iNTT_mode_out(m0),
      .coeff_err(ce0), .len_err(le0)
   );

   ntt_coeff_loader #(.W(W), .N(N), .Modulus_Q(Q), .BITREV(1)) dut1 (
      .clk(clk), .reset(reset), .src(if1), .issue_en(issue_en),
      .Data_out(dout1), .data_valid_out(dv1), .iNTT_mode_out(m1),
      .coeff_err(ce1), .len_err(le1)
   );

   // Reference model: frames waiting (at most two), frames issued awaiting output.
   frame_t      pend[$];
   frame_t      sb[$];
   frame_t      cur;
   int unsigned mcnt = 0;
   bit          m_ce = 1'b0;
   bit          m_le = 1'b0;
   bit          exp_v = 1'b0;
   bit          acc = 1'b0;
   bit          mon_en = 1'b0;
   int          vcnt = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic int unsigned rev_idx(input int unsigned k);
      int unsigned r, x;
      r = 0;
      x = k;
      for (int i = 0; i < int'(LOGN); i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit          rdy;
      logic [W-1:0] v;
      acc = 1'b0;
      if (reset) begin
         pend.delete();
         mcnt  = 0;
         m_ce  = 1'b0;
         m_le  = 1'b0;
         exp_v = 1'b0;
         cur   = '0;
      end else begin
         rdy   = pend.size() < 2;
         exp_v = (pend.size() > 0) && issue_en;
         if (exp_v) sb.push_back(pend.pop_front());
         if (valid && rdy) begin
            acc = 1'b1;
            v = (coeff < Q) ? coeff : '0;
            if (coeff >= Q) m_ce = 1'b1;
            if (last != (mcnt == N - 1)) m_le = 1'b1;
            if (mcnt == 0) cur.mode = mode;
            cur.nat[mcnt]          = v;
            cur.rev[rev_idx(mcnt)] = v;
            if (mcnt == N - 1) begin
               pend.push_back(cur);
               mcnt = 0;
            end else begin
               mcnt++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   // Drive one beat and hold it until accepted; optionally open issue_en after a stall.
   task automatic send_beat(input logic [W-1:0] c, input logic l, input logic md, input int release_after);
      int waited;
      valid = 1'b1;
      coeff = c;
      last  = l;
      mode  = md;
      waited = 0;
      while (1) begin
         step();
         if (acc) break;
         waited++;
         if (release_after >= 0 && waited >= release_after) issue_en = 1'b1;
         if (waited > 100) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got no acceptance in 100 cycles, expected acceptance");
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      last  = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Monitor: per-cycle control checks and scoreboard pop on every issued frame.
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("valid0", 32'(dv0), 32'(exp_v));
            chk("valid1", 32'(dv1), 32'(exp_v));
            chk("ready0", 32'(if0.in_ready), 32'(!reset && pend.size() < 2));
            chk("ready1", 32'(if1.in_ready), 32'(!reset && pend.size() < 2));
            chk("coeff_err0", 32'(ce0), 32'(m_ce));
            chk("coeff_err1", 32'(ce1), 32'(m_ce));
            chk("len_err0", 32'(le0), 32'(m_le));
            chk("len_err1", 32'(le1), 32'(m_le));
            if (dv0 || dv1) begin
               vcnt++;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame_expected: got an issued frame, expected none");
               end else begin
                  f = sb.pop_front();
                  chk("mode0", 32'(m0), 32'(f.mode));
                  chk("mode1", 32'(m1), 32'(f.mode));
                  for (int i = 0; i < int'(N); i++) begin
                     chk($sformatf("data_nat[%0d]", i), dout0[i], f.nat[i]);
                     chk($sformatf("data_rev[%0d]", i), dout1[i], f.rev[i]);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, expected finish; errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] basic [0:N-1];
      logic [W-1:0] lit_rev [0:N-1];
      int           v0;

      basic   = '{32'd123412341, 32'd123412342, 32'd123412343, 32'd123412344,
                  32'd123412345, 32'd0, 32'd0, 32'd0};
      lit_rev = '{32'd123412341, 32'd123412345, 32'd123412343, 32'd0,
                  32'd123412342, 32'd0, 32'd123412344, 32'd0};

      // Reset state
      step();
      mon_en = 1'b1;
      step();
      for (int i = 0; i < int'(N); i++) chk("reset_dout", dout0[i], '0);
      chk("reset_mode", 32'(m0), '0);
      reset = 1'b0;
      issue_en = 1'b1;
      step();

      // Basic frame, natural and bit-reversed
      v0 = vcnt;
      for (int b = 0; b < int'(N); b++) send_beat(basic[b], b == int'(N) - 1, 1'b0, -1);
      idle(3);
      chk("basic_issue_count", 32'(vcnt - v0), 32'd1);
      for (int i = 0; i < int'(N); i++) begin
         chk("basic_nat_lit", dout0[i], basic[i]);
         chk("basic_rev_lit", dout1[i], lit_rev[i]);
      end

      // Range check
      for (int b = 0; b < int'(N); b++) begin
         if (b == 0)      send_beat(Q, 1'b0, 1'b1, -1);
         else if (b == 1) send_beat(Q - 1, 1'b0, 1'b1, -1);
         else             send_beat($urandom % Q, b == int'(N) - 1, 1'b1, -1);
      end
      idle(2);
      chk("range_d0", dout0[0], '0);
      chk("range_d1", dout0[1], Q - 1);
      chk("range_err", 32'(ce0), 32'd1);

      // Backpressure: three frames with issue_en held low, released during the stall
      issue_en = 1'b0;
      v0 = vcnt;
      for (int b = 0; b < 3 * int'(N); b++) begin
         send_beat($urandom % Q, (b % int'(N)) == int'(N) - 1, (b / int'(N)) != 1, 4);
         if (b == 2 * int'(N) - 1) begin
            chk("bp_ready_low", 32'(if0.in_ready), 32'd0);
            chk("bp_no_valid", 32'(vcnt - v0), 32'd0);
         end
      end
      idle(3);
      chk("bp_issue_count", 32'(vcnt - v0), 32'd3);
      chk("bp_coeff_err_sticky", 32'(ce0), 32'd1);

      // in_last on beat 3 instead of beat 7
      v0 = vcnt;
      for (int b = 0; b < int'(N); b++) send_beat($urandom % Q, b == 3, 1'b0, -1);
      idle(3);
      chk("len_err_set", 32'(le0), 32'd1);
      chk("len_err_issue", 32'(vcnt - v0), 32'd1);

      // Reset mid-frame then a clean frame 1..8
      for (int b = 0; b < 5; b++) send_beat($urandom % Q, 1'b0, 1'b1, -1);
      valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      v0 = vcnt;
      for (int b = 0; b < int'(N); b++) send_beat(W'(b + 1), b == int'(N) - 1, 1'b0, -1);
      idle(3);
      chk("rst_issue_count", 32'(vcnt - v0), 32'd1);
      for (int i = 0; i < int'(N); i++) chk("rst_frame", dout0[i], W'(i + 1));
      chk("rst_flags", 32'({ce0, le0, m0}), 32'd0);

      // Randomized traffic with occasional bad coefficients, bad last, stalls and resets
      for (int c = 0; c < 600; c++) begin
         valid    = ($urandom % 4) != 0;
         coeff    = (($urandom % 8) == 0) ? W'($urandom) : W'($urandom % Q);
         last     = (mcnt == N - 1) ^ (($urandom % 16) == 0);
         mode     = 1'($urandom % 2);
         issue_en = ($urandom % 3) != 0;
         reset    = ($urandom % 150) == 0;
         step();
      end
      reset    = 1'b0;
      issue_en = 1'b1;
      idle(8);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("pend_drained", 32'(pend.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ntt_coeff_loader.md
# ntt_coeff_loader

Upstream feeder for `ntt_block_radix2_pipelined`. Accepts one polynomial coefficient per cycle over a valid/ready stream and range-checks each against `Modulus_Q`. It optionally bit-reverse-permutes the coefficients, then assembles N-coefficient frames in a two-bank buffer. Each completed frame is issued as a single-cycle parallel `Data_out` vector with `data_valid_out` and `iNTT_mode_out`, which connect directly to the NTT block's `Data_in`, `data_valid_in` and `iNTT_mode`.

## Interface
- `W`, 32: coefficient width.
- `N`, 8: frame length, a power of two ≥ 2; must equal the NTT's N.
- `Modulus_Q`, 134221489: modulus; must be < 2^W.
- `BITREV`, 0: when 1, coefficient k is stored at index bitrev_log2(N)(k).
- `clk` in 1: clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: an input beat is present.
- `in_ready` out 1: the loader can accept a beat.
- `in_coeff` in W: coefficient value.
- `in_last` in 1: marks the final beat of a frame; checked only, never used to close the frame.
- `in_mode` in 1: NTT/iNTT select; sampled on beat 0 of each frame.
- `issue_en` in 1: permission to issue a full bank this cycle (scheduler stall gate).
- `Data_out` out N×W: unpacked array `[0:N-1]` holding the issued frame.
- `data_valid_out` out 1: one-cycle pulse per issued frame.
- `iNTT_mode_out` out 1: mode of the frame being issued.
- `coeff_err` out 1: sticky flag; some accepted coefficient was ≥ Q.
- `len_err` out 1: sticky flag; `in_last` placement was wrong.

## Operation
- **Beat acceptance:** a beat is accepted at a posedge where `in_valid && in_ready`.
- **State:** two banks, each N×W plus a mode bit. Write pointer `wr_bank`, read pointer `rd_bank`, flags `full[1:0]`, and beat counter `cnt` of width log2(N).
- **Accepted beat:**
  - The stored value is `in_coeff` if `in_coeff < Q`. Otherwise the stored value is 0 and `coeff_err` is set.
  - The destination index is `cnt`, or bitrev(`cnt`) when `BITREV`=1.
  - On `cnt`=0 the beat's `in_mode` is latched into the bank.
  - `in_last` asserted while `cnt`≠N-1, or deasserted while `cnt`=N-1, sets `len_err`.
  - `cnt` increments and wraps from N-1 to 0. On the wrap, `full[wr_bank]` is set and `wr_bank` toggles.
- **Issue:** at a posedge where `full[rd_bank] && issue_en`:
  - `Data_out` and `iNTT_mode_out` load from bank `rd_bank`.
  - `data_valid_out` is 1 in the following cycle.
  - `full[rd_bank]` clears and `rd_bank` toggles.
- **No issue:** when no issue occurs at a posedge, `data_valid_out` is 0 in the following cycle. `Data_out` and `iNTT_mode_out` hold the last issued frame.
- **Ready:** `in_ready` = !`reset` && !`full[wr_bank]`. It depends only on registered state and `reset`; there is no combinational path from `issue_en` or `in_valid`.
- **Same-edge completion and issue:** completion into one bank and issue from the other at the same edge are both performed.
- **Error flags:** cleared only by `reset`.

## Timing
- **Reset values:**
  - `Data_out` all 0; `data_valid_out`, `iNTT_mode_out`, `coeff_err`, `len_err` all 0.
  - `full`=00, `wr_bank`=`rd_bank`=0, `cnt`=0.
- **Reset mid-frame:** discards the partial frame and any full banks. No issue occurs at the reset edge.
- **Latency:** last beat accepted at edge t. With `issue_en` high, issue occurs at edge t+1 and `data_valid_out` is high in the cycle after t+1.
- **Throughput:** one frame per N cycles sustained.
- **Stall depth:** two frames buffer under stall. The first beat after `full[wr_bank]` clears is accepted at the next edge.
- **Issue pacing:** two full banks issue on consecutive edges, so `data_valid_out` is high for 2 cycles.

## Structure
- **Package `ntt_pkg`:**
  - Default `W`/`N`/`Modulus_Q`/`OMEGA` constants.
  - A `coeff_t` typedef (logic [W-1:0]).
  - Function `bitrev(idx, nbits)`.
- **Sub-module `ntt_coeff_bank`:**
  - N×W register array plus mode bit.
  - Write port: enable, index, data.
  - Parallel read of all N words.
  - Instantiated twice.
- **Top-level logic:** control (pointers, `full`, `cnt`, error flags, output registers) stays in `ntt_coeff_loader`.

## Test plan
- **Basic frame (`BITREV`=0, `issue_en`=1):** beats 123412341, 123412342, 123412343, 123412344, 123412345, 0, 0, 0 with `in_last` on beat 7 and `in_mode`=0 → exactly one `data_valid_out` cycle, 1 cycle after the last beat. `Data_out` equals the input order, `iNTT_mode_out`=0, and neither error flag is set.
- **Bit reversal (`BITREV`=1), same stream:** → `Data_out` = [123412341, 123412345, 123412343, 0, 123412342, 0, 123412344, 0].
- **Range check:** beat 0 = 134221489 (=Q), beat 1 = 134221488 → `Data_out[0]`=0, `Data_out[1]`=134221488, `coeff_err`=1 and stays 1 through later clean frames.
- **Backpressure:** `issue_en`=0 while driving 24 beats continuously (`in_mode` 1, 0, 1 per frame) → `in_ready` drops after beat 16 and no valid is produced. Raise `issue_en` → valid on 2 consecutive cycles with modes 1 then 0, `in_ready` returns the cycle after the first issue, and the third frame issues one cycle after its last beat.
- **`in_last` errors:** `in_last` on beat 3 → `len_err`=1, and the frame still closes after 8 beats and issues.
- **Reset mid-frame:** 5 beats, `reset` for 1 cycle, then a full 8-beat frame of 1..8 → single issue, `Data_out`=1..8, all flags 0.
